// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder speed front end.
// Holds widths, direction codes, and the (prev, cur) Gray-code step decoder.
package encoder_pkg;

    localparam int FEED_W = 8;
    localparam int ACC_W  = 16;

    typedef logic [1:0] quad_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef struct packed {
        logic inc;
        logic dec;
        logic illegal;
    } quad_evt_t;

    // Position of a {A,B} state on the forward cycle 00->10->11->01.
    function automatic logic [1:0] quad_pos(quad_state_t s);
        return {s[0], s[1] ^ s[0]};
    endfunction

    // One step forward is +1 mod 4, back is -1, a jump of 2 is illegal.
    function automatic quad_evt_t quad_decode(quad_state_t prev,
                                              quad_state_t cur);
        logic [1:0] step;
        quad_evt_t  e;
        step      = quad_pos(cur) - quad_pos(prev);
        e.inc     = (step == 2'd1);
        e.dec     = (step == 2'd3);
        e.illegal = (step == 2'd2);
        return e;
    endfunction

endpackage

// File: rtl/encoder_speed_meas_if.sv
// Speed result bundle delivered to the PID feedback input.
// master drives feed/dir/feed_valid/enc_err; slave observes them.
interface encoder_speed_meas_if;
    import encoder_pkg::*;

    logic [FEED_W-1:0] feed;
    logic              dir;
    logic              feed_valid;
    logic              enc_err;

    modport master (output feed, output dir,
                    output feed_valid, output enc_err);
    modport slave  (input feed, input dir,
                    input feed_valid, input enc_err);

endinterface

// File: rtl/encoder_speed_meas_quad_decoder.sv
// Synchronises the A/B pins and decodes 4x quadrature steps.
// Ports: clk, reset, enc_a, enc_b in; inc, dec, illegal single-cycle pulses out.
module quad_decoder
    import encoder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic inc,
    output logic dec,
    output logic illegal
);

    quad_state_t s1;
    quad_state_t cur;
    quad_state_t prev;
    logic [1:0]  fill;
    logic        primed;
    quad_evt_t   evt;

    // The synchroniser holds reset zeros for two cycles after release,
    // so priming waits for the first real pin sample to reach cur.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            cur    <= '0;
            prev   <= '0;
            fill   <= '0;
            primed <= 1'b0;
        end else begin
            s1   <= {enc_a, enc_b};
            cur  <= s1;
            prev <= cur;
            fill <= {fill[0], 1'b1};
            if (fill[1]) begin
                primed <= 1'b1;
            end
        end
    end

    assign evt     = quad_decode(prev, cur);
    assign inc     = primed & evt.inc;
    assign dec     = primed & evt.dec;
    assign illegal = primed & evt.illegal;

endmodule

// File: rtl/encoder_speed_meas.sv
// Quadrature encoder speed meter: signed edge count per fixed window.
// Ports: clk, reset, enc_a, enc_b in; out (master) carries feed/dir/valid/err.
module encoder_speed_meas
    import encoder_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100000,
    parameter bit INVERT_DIR    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    encoder_speed_meas_if.master out
);

    localparam int WCNT_W = $clog2(WINDOW_CYCLES);

    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WONE  = 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE = 1;
    localparam logic [ACC_W:0]          MAG_ONE = 1;

    logic inc;
    logic dec;
    logic illegal;
    logic up;
    logic dn;
    logic terminal;
    logic err_w;
    logic err_nxt;

    logic [WCNT_W-1:0]       wcnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [ACC_W:0]          ext;
    logic [ACC_W:0]          mag;
    logic [FEED_W-1:0]       feed_nxt;

    quad_decoder u_dec (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .inc     (inc),
        .dec     (dec),
        .illegal (illegal)
    );

    assign up       = INVERT_DIR ? dec : inc;
    assign dn       = INVERT_DIR ? inc : dec;
    assign terminal = (wcnt == WLAST);
    assign err_nxt  = err_w | illegal;

    // Saturating accumulate, then a 17-bit magnitude so -32768 is exact.
    always_comb begin
        acc_nxt = acc;
        if (up && acc != ACC_MAX) begin
            acc_nxt = acc + ACC_ONE;
        end else if (dn && acc != ACC_MIN) begin
            acc_nxt = acc - ACC_ONE;
        end
        ext      = {acc_nxt[ACC_W-1], acc_nxt};
        mag      = acc_nxt[ACC_W-1] ? (~ext + MAG_ONE) : ext;
        feed_nxt = (|mag[ACC_W:FEED_W]) ? '1 : mag[FEED_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt           <= '0;
            acc            <= '0;
            err_w          <= 1'b0;
            out.feed       <= '0;
            out.dir        <= DIR_FWD;
            out.feed_valid <= 1'b0;
            out.enc_err    <= 1'b0;
        end else begin
            out.feed_valid <= terminal;
            if (terminal) begin
                wcnt        <= '0;
                acc         <= '0;
                err_w       <= 1'b0;
                out.feed    <= feed_nxt;
                out.enc_err <= err_nxt;
                if (acc_nxt != '0) begin
                    out.dir <= acc_nxt[ACC_W-1] ? DIR_REV : DIR_FWD;
                end
            end else begin
                wcnt  <= wcnt + WONE;
                acc   <= acc_nxt;
                err_w <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_encoder_speed_meas.sv
// Bench for encoder_speed_meas: two instances (100-cycle forward sense,
// 1000-cycle inverted sense) driven from shared pins against a window model.
module tb_encoder_speed_meas;
    import encoder_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;

    always #5 clk = ~clk;

    encoder_speed_meas_if if0 ();
    encoder_speed_meas_if if1 ();

    encoder_speed_meas #(
        .WINDOW_CYCLES (100),
        .INVERT_DIR    (1'b0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .out   (if0.master)
    );

    encoder_speed_meas #(
        .WINDOW_CYCLES (1000),
        .INVERT_DIR    (1'b1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .out   (if1.master)
    );

    // Each applied pin step: cycle it is decoded in, signed intent, illegal.
    typedef struct {
        int d;
        int delta;
        bit ill;
    } ev_t;

    ev_t evq[$];

    int tests = 0;
    int fails = 0;
    int m     = 0;
    int pos   = 0;

    int win_w[2]   = '{100, 1000};
    bit win_inv[2] = '{1'b0, 1'b1};
    int exp_feed[2];
    int exp_dir[2];
    int exp_err[2];

    logic [1:0] seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // kind: 1 forward, -1 reverse, 0 illegal jump of both pins.
    task automatic step(int kind);
        ev_t e;
        e.d     = m + 2;
        e.delta = kind;
        e.ill   = (kind == 0);
        if (kind == 1) begin
            pos = (pos + 1) % 4;
        end else if (kind == -1) begin
            pos = (pos + 3) % 4;
        end else begin
            pos = (pos + 2) % 4;
        end
        {enc_a, enc_b} = seq[pos];
        evq.push_back(e);
    endtask

    task automatic close_win(int u, int k);
        int s;
        int a;
        bit e;
        int lo;
        int hi;
        s  = 0;
        e  = 1'b0;
        lo = k * win_w[u];
        hi = lo + win_w[u];
        foreach (evq[i]) begin
            if (evq[i].d >= lo && evq[i].d < hi) begin
                if (evq[i].ill) begin
                    e = 1'b1;
                end else begin
                    s += win_inv[u] ? -evq[i].delta : evq[i].delta;
                    if (s > 32767) s = 32767;
                    if (s < -32768) s = -32768;
                end
            end
        end
        a = (s < 0) ? -s : s;
        exp_feed[u] = (a > 255) ? 255 : a;
        if (s != 0) exp_dir[u] = (s < 0) ? 1 : 0;
        exp_err[u] = e;
    endtask

    task automatic check_dut(int u, logic [7:0] f, logic d,
                             logic v, logic e);
        chk($sformatf("feed%0d", u), f, exp_feed[u]);
        chk($sformatf("dir%0d", u), d, exp_dir[u]);
        chk($sformatf("err%0d", u), e, exp_err[u]);
        chk($sformatf("valid%0d", u), v, (m > 0 && m % win_w[u] == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m++;
        for (int u = 0; u < 2; u++) begin
            if (m % win_w[u] == 0) close_win(u, m / win_w[u] - 1);
        end
        check_dut(0, if0.feed, if0.dir, if0.feed_valid, if0.enc_err);
        check_dut(1, if1.feed, if1.dir, if1.feed_valid, if1.enc_err);
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic to_phase(int w, int r);
        while (m % w != r) tick();
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        m     = 0;
        evq.delete();
        for (int u = 0; u < 2; u++) begin
            exp_feed[u] = 0;
            exp_dir[u]  = 0;
            exp_err[u]  = 0;
        end
        check_dut(0, if0.feed, if0.dir, if0.feed_valid, if0.enc_err);
        check_dut(1, if1.feed, if1.dir, if1.feed_valid, if1.enc_err);
    endtask

    initial begin
        int r;
        do_reset(3);

        // Forward, one edge every 10 cycles.
        run(5);
        for (int i = 0; i < 40; i++) begin
            step(1);
            run(10);
        end
        chk("fwd_feed", if0.feed, 10);
        chk("fwd_dir", if0.dir, 0);
        chk("fwd_err", if0.enc_err, 0);

        // Reverse, same rate.
        for (int i = 0; i < 30; i++) begin
            step(-1);
            run(10);
        end
        chk("rev_feed", if0.feed, 10);
        chk("rev_dir", if0.dir, 1);

        // Five forward edges around one illegal jump.
        to_phase(100, 5);
        step(1);  run(10);
        step(1);  run(10);
        step(0);  run(10);
        step(1);  run(10);
        step(1);  run(10);
        step(1);  run(10);
        to_phase(100, 1);
        chk("ill_feed", if0.feed, 5);
        chk("ill_err", if0.enc_err, 1);

        // Clean window afterwards.
        to_phase(100, 5);
        for (int i = 0; i < 3; i++) begin
            step(1);
            run(10);
        end
        to_phase(100, 1);
        chk("clean_feed", if0.feed, 3);
        chk("clean_err", if0.enc_err, 0);
        chk("clean_dir", if0.dir, 0);

        // Edge decoded on the terminal cycle, then one just after it.
        to_phase(100, 97);
        step(1);
        run(2);
        step(1);
        to_phase(100, 0);
        chk("term_edge", if0.feed, 1);
        chk("term_valid", if0.feed_valid, 1);
        tick();
        to_phase(100, 0);
        chk("next_win", if0.feed, 1);

        // Random walk with occasional illegal jumps.
        while (m < 2700) begin
            r = $urandom_range(0, 19);
            if (r < 1) step(0);
            else if (r < 8) step(-1);
            else step(1);
            run($urandom_range(2, 8));
        end

        // Reverse at the maximum rate: inverted long window saturates.
        to_phase(1000, 0);
        repeat (1100) begin
            step(-1);
            run(2);
        end
        chk("sat_feed1", if1.feed, 255);
        chk("sat_dir1", if1.dir, 0);
        chk("sat_feed0", if0.feed, 50);
        chk("sat_dir0", if0.dir, 1);

        // Encoder stopped: zero count, direction held.
        run(2000);
        chk("idle_feed1", if1.feed, 0);
        chk("idle_dir1", if1.dir, 0);

        // Three edges, reset at wcnt 50 with a non-zero pin state held.
        while (pos != 0) begin
            step(1);
            run(4);
        end
        to_phase(100, 10);
        for (int i = 0; i < 3; i++) begin
            step(1);
            run(10);
        end
        to_phase(100, 50);
        do_reset(1);
        chk("rst_pins", {enc_a, enc_b}, 2'b01);
        run(49);
        chk("old_bound", if0.feed_valid, 0);
        run(51);
        chk("first_valid", if0.feed_valid, 1);
        chk("held_feed", if0.feed, 0);
        run(150);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
